// File: rtl/oled_cursor_overlay.sv
// Mouse cursor overlay for the 96x64 OLED pixel stream: scales MouseCtl coordinates,
// latches cursor state once per frame and paints the cursor shape over bg_data.
// Optional blinking cursor is built when CURSOR_BLINK_EN is defined.
module oled_cursor_overlay #(
    parameter int          DISP_W        = 96,
    parameter int          DISP_H        = 64,
    parameter int          PIX_W         = 13,
    parameter int          MOUSE_XMAX    = 640,
    parameter int          MOUSE_YMAX    = 480,
    parameter int          CURSOR_SIZE   = 3,
    parameter logic [15:0] CURSOR_COLOUR = 16'hF800,
    parameter logic [15:0] CLICK_COLOUR  = 16'h07E0
`ifdef CURSOR_BLINK_EN
    ,
    parameter int          BLINK_FRAMES  = 30
`endif
) (
    input  logic             basys_clock,
    input  logic             reset_n,
    input  logic [11:0]      xpos,
    input  logic [11:0]      ypos,
    input  logic             left,
    input  logic             middle,
    input  logic             frame_begin,
    input  logic [PIX_W-1:0] pixel_index,
    input  logic [15:0]      bg_data,
    output logic [15:0]      pixel_data,
    output logic [6:0]       cursor_x,
    output logic [5:0]       cursor_y,
    output logic [1:0]       mode
);

    localparam logic [PIX_W:0]   HALF = (PIX_W+1)'(CURSOR_SIZE / 2);
    localparam logic [PIX_W-1:0] NPIX = PIX_W'(DISP_W * DISP_H);

    logic [15:0] pixel_data_q, pixel_data_d;
    logic [6:0]  cursor_x_q, cursor_x_d;
    logic [5:0]  cursor_y_q, cursor_y_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  mode_next_q, mode_next_d;
    logic        frame_begin_q, middle_q;

    logic        frame_edge, middle_edge, visible;
    logic [23:0] x_scaled, y_scaled;
    logic [6:0]  sx;
    logic [5:0]  sy;

    assign frame_edge  = frame_begin & ~frame_begin_q;
    assign middle_edge = middle & ~middle_q;

    // Constant divisors, so synthesis reduces these to multiply-by-reciprocal logic.
    assign x_scaled = (24'(xpos) * 24'(DISP_W)) / 24'(MOUSE_XMAX);
    assign y_scaled = (24'(ypos) * 24'(DISP_H)) / 24'(MOUSE_YMAX);
    assign sx = (x_scaled >= 24'(DISP_W)) ? 7'(DISP_W - 1) : x_scaled[6:0];
    assign sy = (y_scaled >= 24'(DISP_H)) ? 6'(DISP_H - 1) : y_scaled[5:0];

    logic [PIX_W-1:0]        px, py;
    logic signed [PIX_W:0]   dx, dy;
    logic [PIX_W:0]          ax, ay;
    logic                    in_square, hit;

    assign px = pixel_index % PIX_W'(DISP_W);
    assign py = pixel_index / PIX_W'(DISP_W);
    // One extra sign bit keeps left/top overhang negative instead of wrapping.
    assign dx = $signed({1'b0, px}) - $signed({{(PIX_W-6){1'b0}}, cursor_x_q});
    assign dy = $signed({1'b0, py}) - $signed({{(PIX_W-5){1'b0}}, cursor_y_q});
    assign ax = dx[PIX_W] ? $unsigned(-dx) : $unsigned(dx);
    assign ay = dy[PIX_W] ? $unsigned(-dy) : $unsigned(dy);
    assign in_square = (ax <= HALF) && (ay <= HALF);

    always_comb begin
        hit = 1'b0;
        unique case (mode_q)
            2'd0:    hit = (dx == 0) && (dy == 0);
            2'd1:    hit = in_square;
            2'd2:    hit = ((dx == 0) && (ay <= HALF)) || ((dy == 0) && (ax <= HALF));
            default: hit = in_square && ((ax == HALF) || (ay == HALF));
        endcase
    end

`ifdef CURSOR_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_on_q, blink_on_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_edge) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign visible = blink_on_q | left;
`else
    assign visible = 1'b1;
`endif

    always_comb begin
        cursor_x_d  = cursor_x_q;
        cursor_y_d  = cursor_y_q;
        mode_d      = mode_q;
        mode_next_d = mode_next_q;
        if (middle_edge)
            mode_next_d = mode_next_q + 2'd1;
        // A coincident middle edge is picked up by the following frame.
        if (frame_edge) begin
            cursor_x_d = sx;
            cursor_y_d = sy;
            mode_d     = mode_next_q;
        end
        pixel_data_d = bg_data;
        if ((pixel_index < NPIX) && hit && visible)
            pixel_data_d = left ? CLICK_COLOUR : CURSOR_COLOUR;
    end

    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_data_q  <= '0;
            cursor_x_q    <= '0;
            cursor_y_q    <= '0;
            mode_q        <= '0;
            mode_next_q   <= '0;
            frame_begin_q <= 1'b1;
            middle_q      <= 1'b1;
        end else begin
            pixel_data_q  <= pixel_data_d;
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            mode_q        <= mode_d;
            mode_next_q   <= mode_next_d;
            frame_begin_q <= frame_begin;
            middle_q      <= middle;
        end
    end

    assign pixel_data = pixel_data_q;
    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_oled_cursor_overlay.sv
// Randomised bench for oled_cursor_overlay against an arithmetic reference model,
// plus literal expectations for the documented scenarios.
module tb_oled_cursor_overlay;

    logic        basys_clock = 1'b0;
    logic        reset_n;
    logic [11:0] xpos, ypos;
    logic        left, middle, frame_begin;
    logic [12:0] pixel_index;
    logic [15:0] bg_data;
    logic [15:0] pixel_data;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [1:0]  mode;

    always #5 basys_clock = ~basys_clock;

`ifdef CURSOR_BLINK_EN
    localparam int BF = 2;
    oled_cursor_overlay #(.BLINK_FRAMES(BF)) dut (
`else
    oled_cursor_overlay dut (
`endif
        .basys_clock(basys_clock), .reset_n(reset_n), .xpos(xpos), .ypos(ypos),
        .left(left), .middle(middle), .frame_begin(frame_begin),
        .pixel_index(pixel_index), .bg_data(bg_data), .pixel_data(pixel_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .mode(mode));

    // ---------------- reference model ----------------
    int          m_cx, m_cy, m_mode, m_mnext, m_frames;
    logic        m_fbp, m_midp;
    logic [15:0] m_exp;

    function automatic bit vis_of(int frames);
`ifdef CURSOR_BLINK_EN
        return ((frames / BF) % 2) == 0;
`else
        return frames >= 0;
`endif
    endfunction

    function automatic int scale(int v, int mul, int div, int lim);
        int r;
        r = v * mul / div;
        return (r >= lim) ? lim - 1 : r;
    endfunction

    function automatic logic [15:0] exp_pixel(int idx, logic [15:0] bg, logic lft,
                                              int cx, int cy, int md, bit vis);
        int dx, dy, ax, ay;
        bit hit;
        if (idx >= 96 * 64) return bg;
        dx = idx % 96 - cx;
        dy = idx / 96 - cy;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        case (md)
            0:       hit = (ax == 0) && (ay == 0);
            1:       hit = (ax <= 1) && (ay <= 1);
            2:       hit = ((ax == 0) && (ay <= 1)) || ((ay == 0) && (ax <= 1));
            default: hit = (ax <= 1) && (ay <= 1) && ((ax == 1) || (ay == 1));
        endcase
        if (hit && (vis || lft)) return lft ? 16'h07E0 : 16'hF800;
        return bg;
    endfunction

    always @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            m_exp <= 16'h0; m_cx <= 0; m_cy <= 0; m_mode <= 0; m_mnext <= 0;
            m_frames <= 0; m_fbp <= 1'b1; m_midp <= 1'b1;
        end else begin
            m_exp  <= exp_pixel(int'(pixel_index), bg_data, left, m_cx, m_cy, m_mode,
                                vis_of(m_frames));
            m_midp <= middle;
            m_fbp  <= frame_begin;
            if (middle && !m_midp) m_mnext <= (m_mnext + 1) % 4;
            if (frame_begin && !m_fbp) begin
                m_cx     <= scale(int'(xpos), 96, 640, 96);
                m_cy     <= scale(int'(ypos), 64, 480, 64);
                m_mode   <= m_mnext;
                m_frames <= m_frames + 1;
            end
        end
    end

    // ---------------- compare process ----------------
    int          n_chk = 0, n_fail = 0;
    bit          chk_on = 1'b0;
    bit          lit_pix_en = 1'b0, lit_xy_en = 1'b0;
    logic [15:0] lit_pix;
    int          lit_x, lit_y, lit_mode;

    always @(negedge basys_clock) begin
        #1;
        if (chk_on) begin
            n_chk++;
            if (pixel_data !== m_exp) begin
                n_fail++;
                $display("FAIL model_pixel t=%0t got %h want %h", $time, pixel_data, m_exp);
            end
            n_chk++;
            if (cursor_x !== 7'(m_cx) || cursor_y !== 6'(m_cy) || mode !== 2'(m_mode)) begin
                n_fail++;
                $display("FAIL model_state t=%0t got x=%0d y=%0d m=%0d want x=%0d y=%0d m=%0d",
                         $time, cursor_x, cursor_y, mode, m_cx, m_cy, m_mode);
            end
            if (lit_pix_en) begin
                n_chk++;
                if (pixel_data !== lit_pix) begin
                    n_fail++;
                    $display("FAIL lit_pixel t=%0t idx=%0d got %h want %h",
                             $time, pixel_index, pixel_data, lit_pix);
                end
            end
            if (lit_xy_en) begin
                n_chk++;
                if (cursor_x !== 7'(lit_x) || cursor_y !== 6'(lit_y) || mode !== 2'(lit_mode)) begin
                    n_fail++;
                    $display("FAIL lit_state t=%0t got x=%0d y=%0d m=%0d want x=%0d y=%0d m=%0d",
                             $time, cursor_x, cursor_y, mode, lit_x, lit_y, lit_mode);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge basys_clock);
        lit_pix_en = 1'b0;
        lit_xy_en  = 1'b0;
    endtask

    task automatic frame();
        step(); frame_begin = 1'b1;
        repeat (16) step();
        frame_begin = 1'b0;
        repeat (2) step();
    endtask

    task automatic pulse_mid();
        step(); middle = 1'b1;
        repeat (3) step();
        middle = 1'b0;
        step();
    endtask

    task automatic chk_xy(input int x, input int y, input int m);
        step();
        lit_xy_en = 1'b1; lit_x = x; lit_y = y; lit_mode = m;
    endtask

    task automatic px(input int idx, input logic [15:0] colour, input bit want_bg);
        step();
        pixel_index = 13'(idx);
        bg_data     = 16'($urandom);
        step();
        lit_pix_en = 1'b1;
        lit_pix    = want_bg ? bg_data : colour;
    endtask

    function automatic bit shown();
        return vis_of(m_frames) || left;
    endfunction

    initial begin
        int x, y, idx;
        reset_n = 1'b0; xpos = '0; ypos = '0; left = 1'b0; middle = 1'b1;
        frame_begin = 1'b0; pixel_index = '0; bg_data = 16'h1234;
        repeat (3) @(negedge basys_clock);
        chk_on = 1'b1;
        lit_pix_en = 1'b1; lit_pix = 16'h0;
        lit_xy_en = 1'b1; lit_x = 0; lit_y = 0; lit_mode = 0;
        step(); reset_n = 1'b1;
        step(); middle = 1'b0;

        // T1: centre of the mouse range lands at display centre, DOT shape
        xpos = 12'd320; ypos = 12'd240;
        frame(); chk_xy(48, 32, 0);
        px(3120, 16'hF800, !shown());
        px(3121, 16'h0, 1'b1);

        // T2: SQUARE after one middle click, four clicks wrap back to DOT
        pulse_mid(); frame(); chk_xy(48, 32, 1);
        px(3121, 16'hF800, !shown());
        px(3024, 16'hF800, !shown());
        px(3216, 16'hF800, !shown());
        px(3122, 16'h0, 1'b1);
        pulse_mid(); pulse_mid(); pulse_mid();
        frame(); chk_xy(48, 32, 0);

        // T3: clamp to bottom-right; coincident click and frame edge defers the mode step
        xpos = 12'd700; ypos = 12'd500;
        step(); frame_begin = 1'b1; middle = 1'b1;
        repeat (16) step();
        frame_begin = 1'b0; middle = 1'b0;
        repeat (2) step();
        chk_xy(95, 63, 0);
        frame(); chk_xy(95, 63, 1);
        px(6143, 16'hF800, !shown());
        px(6047, 16'hF800, !shown());
        px(6048, 16'h0, 1'b1);

        // T4: top-left corner, CROSS, click colour
        xpos = 12'd0; ypos = 12'd0;
        pulse_mid(); frame(); chk_xy(0, 0, 2);
        left = 1'b1;
        px(0, 16'h07E0, 1'b0);
        px(1, 16'h07E0, 1'b0);
        px(96, 16'h07E0, 1'b0);
        px(95, 16'h0, 1'b1);

        // T5: reset while the cursor is on screen, middle held through release
        step(); reset_n = 1'b0; middle = 1'b1;
        lit_pix_en = 1'b1; lit_pix = 16'h0;
        lit_xy_en = 1'b1; lit_x = 0; lit_y = 0; lit_mode = 0;
        step(); step(); reset_n = 1'b1;
        repeat (3) step();
        middle = 1'b0; left = 1'b0;
        xpos = 12'd320; ypos = 12'd240;
        frame(); chk_xy(48, 32, 0);

`ifdef CURSOR_BLINK_EN
        // T6: two frames visible, two hidden; left click overrides the hidden phase
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) frame();
            px(3120, 16'hF800, (k == 2) || (k == 3));
            if (k == 2) begin
                left = 1'b1;
                px(3120, 16'h07E0, 1'b0);
                left = 1'b0;
            end
        end
`endif

        // Random phase, checked cycle-by-cycle against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            frame_begin = ((i % 60) < 20);
            if ($urandom_range(0, 29) == 0) middle = ~middle;
            if ($urandom_range(0, 49) == 0) left = ~left;
            if ($urandom_range(0, 39) == 0) begin
                xpos = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 639));
                ypos = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 1) == 1) begin
                x = m_cx + $urandom_range(0, 6) - 3;
                y = m_cy + $urandom_range(0, 6) - 3;
                idx = y * 96 + x;
                if (idx < 0 || idx > 8191) idx = $urandom_range(0, 8191);
            end else begin
                idx = $urandom_range(0, 8191);
            end
            pixel_index = 13'(idx);
            bg_data = 16'($urandom);
            if (i == 2000) reset_n = 1'b0;
            if (i == 2003) reset_n = 1'b1;
        end

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
